note_decoder: RTL and testbench
===============================

NOTE_DECODER -- requirements
Module: note_decoder

Interface
REQ-001 Parameter TOL_SHIFT, default 6: match tolerance is nominal period >> TOL_SHIFT (about 1.6 %).
REQ-002 Parameter LOCK_COUNT, default 2: consecutive matching periods required before a note is reported.
REQ-003 CLOCK_50  input  1  sole clock, 50 MHz, rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 wave_in  input  1  asynchronous square wave from GPIO pin.
REQ-006 enable  input  1  1 = measure; 0 = hold outputs, FSM to IDLE.
REQ-007 note  output  3  decoded note index, 0 = C4 ... 7 = C5.
REQ-008 note_valid  output  1  one-cycle pulse when note is updated.
REQ-009 locked  output  1  high while the current period matches the reported note.
REQ-010 no_signal  output  1  high when no rising edge occurs within 2^18 cycles.
REQ-011 period  output  18  most recent measured rising-to-rising period, in CLOCK_50 cycles.

Function
REQ-012 wave_in SHALL pass through a 2-FF synchronizer; a rising edge SHALL be detected one cycle after the synchronized signal goes 0->1.
REQ-013 Edge-to-internal latency: a wave_in rise before clock edge k SHALL register as an edge at cycle k+2.
REQ-014 FSM states: IDLE, ARM, MEASURE, DECIDE.
- IDLE -> ARM when enable=1.
- ARM -> MEASURE on the first rising edge; the counter clears to 1.
- MEASURE increments the counter each cycle.
- MEASURE -> DECIDE on the next rising edge; period latches the counter value, and the counter restarts at 1 in the same cycle.
- DECIDE -> MEASURE after one cycle.
REQ-015 Edges arriving while in DECIDE SHALL be counted as part of the new measurement; no edge SHALL be lost.
REQ-016 Nominal full periods (package constants), for 0..7: 191110, 170265, 151685, 143172, 127551, 113636, 101239, 95556.
REQ-017 DECIDE SHALL match note i when |period - NOM[i]| <= NOM[i] >> TOL_SHIFT.
- At most one i can match.
- Compare using unsigned 19-bit arithmetic, with no wrap.
REQ-018 Consecutive matches of the same index SHALL increment a match counter.
- A mismatch or a different index resets the counter to 1 for the new index, or to 0 if nothing matched.
REQ-019 When the match counter reaches LOCK_COUNT and the index differs from note (or locked=0):
- note updates;
- note_valid pulses for exactly one cycle;
- locked sets.
REQ-020 A matching period equal to the already locked note SHALL keep locked=1 without a note_valid pulse.
REQ-021 A non-matching period SHALL clear locked the cycle after DECIDE; note SHALL retain its last value.
REQ-022 If the counter reaches 2^18-1 in ARM or MEASURE:
- the counter saturates;
- no_signal sets and locked clears;
- the FSM returns to ARM.
- no_signal clears on the next rising edge.
REQ-023 enable=0 SHALL force IDLE next cycle and clear the counter and match count; note, period, locked and no_signal hold.
REQ-024 Reset, or enable low mid-measurement, SHALL discard the partial period without producing a note_valid pulse.

Reset
REQ-025 On reset_n=0 at a CLOCK_50 edge:
- note=0, note_valid=0, locked=0, no_signal=0, period=0;
- FSM=IDLE;
- counter, match count and synchronizer flops cleared.
REQ-026 Reset SHALL take priority over all other events in the same cycle.

Structure
REQ-027 Package note_pkg SHALL hold the NOM period table, period width (18), note width (3), the FSM state type and TOL_SHIFT default; the tone generator shares this table.
REQ-028 One sub-module, edge_sync (2-FF synchronizer plus rising-edge pulse), SHALL be instantiated; all other logic stays in note_decoder.
REQ-029 Tolerance compare SHALL be eight parallel comparators feeding a one-hot-to-index encoder; no dividers.

Verification
REQ-030 Square wave, period 113636 cycles, for 4 periods after enable:
- note_valid pulses once with note=5;
- locked=1;
- period=113636.
REQ-031 Period changes from 113636 to 95556 mid-stream:
- locked clears after the first 95556 period;
- after the second, note=7 with a single note_valid pulse.
REQ-032 Period 110000 (between A and B, outside tolerance): no note_valid pulse; locked=0; note holds its prior value; period=110000.
REQ-033 wave_in held low for 300000 cycles after lock:
- no_signal=1 by cycle 2^18 after the last edge;
- locked=0;
- the next edge clears no_signal.
REQ-034 reset_n=0 for one cycle mid-measurement:
- all outputs are 0 the next cycle;
- the following 2 periods of 191110 produce note=0 with a note_valid pulse.
REQ-035 Boundary check, NOM 101239 with tolerance 1581:
- periods of 102820 match;
- 102821 does not.

Source files
------------

// File: rtl/note_pkg.sv
// note_pkg
// Shared constants and types for the note decoder and the tone generator.
// Holds the nominal full-period table for C4..C5 (in 50 MHz clock cycles),
// the period and note widths, the decoder FSM state type, the default
// tolerance shift and the tolerance-compare helper.
package note_pkg;

  localparam int PERIOD_W          = 18;
  localparam int NOTE_W            = 3;
  localparam int NUM_NOTES         = 8;
  localparam int TOL_SHIFT_DEFAULT = 6;

  typedef logic [PERIOD_W-1:0] period_t;
  typedef logic [NOTE_W-1:0]   note_t;

  // Nominal rising-to-rising periods, index 0 = C4 ... 7 = C5.
  localparam period_t NOM_PERIOD [NUM_NOTES] = '{
    18'd191110, 18'd170265, 18'd151685, 18'd143172,
    18'd127551, 18'd113636, 18'd101239, 18'd95556
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE,
    ST_DECIDE
  } state_t;

  // True when |measured - nominal| <= nominal >> shift.
  // One extra bit of headroom keeps the subtraction free of wrap-around.
  function automatic logic within_tol(input period_t measured,
                                      input period_t nominal,
                                      input int      shift);
    logic [PERIOD_W:0] m;
    logic [PERIOD_W:0] n;
    logic [PERIOD_W:0] diff;
    logic [PERIOD_W:0] tol;
    m    = {1'b0, measured};
    n    = {1'b0, nominal};
    diff = (m >= n) ? (m - n) : (n - m);
    tol  = n >> shift;
    return (diff <= tol);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// edge_sync
// Brings an asynchronous square wave into the clock domain through a
// two-flop synchronizer and produces a one-cycle pulse when the
// synchronized signal has just gone from 0 to 1.
// Ports:
//   clk        - clock, rising edge
//   reset_n    - synchronous active-low reset, clears all flops
//   async_in   - asynchronous input (GPIO pin)
//   rise_pulse - high for one cycle after the synchronized rising edge
module edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic sync_meta;
  logic sync_stable;
  logic sync_prev;

  // sync_meta may go metastable; only sync_stable and its delayed copy
  // are used for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_meta   <= 1'b0;
      sync_stable <= 1'b0;
      sync_prev   <= 1'b0;
    end else begin
      sync_meta   <= async_in;
      sync_stable <= sync_meta;
      sync_prev   <= sync_stable;
    end
  end

  assign rise_pulse = sync_stable & ~sync_prev;

endmodule

// File: rtl/note_decoder.sv
// note_decoder
// Measures the rising-to-rising period of a square wave on a GPIO pin and
// reports which of eight notes (C4..C5) it matches once LOCK_COUNT
// consecutive periods agree.
// Parameters:
//   TOL_SHIFT  - match tolerance is nominal >> TOL_SHIFT
//   LOCK_COUNT - consecutive matching periods needed before reporting
// Ports:
//   CLOCK_50   - 50 MHz clock, rising edge
//   reset_n    - synchronous active-low reset
//   wave_in    - asynchronous square wave input
//   enable     - 1 = measure, 0 = hold outputs and idle
//   note       - decoded note index (0 = C4 ... 7 = C5)
//   note_valid - one-cycle pulse when note is updated
//   locked     - current period matches the reported note
//   no_signal  - no rising edge seen for 2^18 cycles
//   period     - last measured period in CLOCK_50 cycles
module note_decoder
  import note_pkg::*;
#(
  parameter int TOL_SHIFT  = TOL_SHIFT_DEFAULT,
  parameter int LOCK_COUNT = 2
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic                wave_in,
  input  logic                enable,
  output logic [NOTE_W-1:0]   note,
  output logic                note_valid,
  output logic                locked,
  output logic                no_signal,
  output logic [PERIOD_W-1:0] period
);

  localparam period_t  COUNT_MAX = '1;
  localparam logic [7:0] LOCK_CNT = 8'(LOCK_COUNT);

  state_t  state;
  state_t  state_next;
  period_t count;
  logic    edge_det;
  logic    timeout;

  logic [NUM_NOTES-1:0] match_hot;
  logic                 any_match;
  note_t                match_idx;
  note_t                match_last;
  logic [7:0]           match_cnt;
  logic [7:0]           match_cnt_next;

  edge_sync u_edge_sync (
    .clk        (CLOCK_50),
    .reset_n    (reset_n),
    .async_in   (wave_in),
    .rise_pulse (edge_det)
  );

  // The counter has run out without an edge while waiting or measuring.
  assign timeout = ((state == ST_ARM) || (state == ST_MEASURE)) &&
                   !edge_det && (count == COUNT_MAX);

  // One tolerance comparator per note; tolerance windows never overlap,
  // so at most one bit of match_hot is set.
  for (genvar i = 0; i < NUM_NOTES; i++) begin : g_cmp
    assign match_hot[i] = within_tol(period, NOM_PERIOD[i], TOL_SHIFT);
  end

  // One-hot to index encoder.
  always_comb begin
    match_idx = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (match_hot[i]) begin
        match_idx = NOTE_W'(i);
      end
    end
    any_match = |match_hot;
  end

  // Running count of consecutive periods that matched the same note,
  // saturating at LOCK_CNT so it cannot wrap on a long steady tone.
  always_comb begin
    match_cnt_next = 8'd1;
    if ((match_cnt != 8'd0) && (match_idx == match_last)) begin
      match_cnt_next = (match_cnt >= LOCK_CNT) ? LOCK_CNT : (match_cnt + 8'd1);
    end
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state. An edge seen in DECIDE closes another period
  // immediately, so DECIDE re-enters itself rather than dropping it.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (enable) state_next = ST_ARM;
      ST_ARM:     if (edge_det) state_next = ST_MEASURE;
      ST_MEASURE: begin
        if (edge_det) begin
          state_next = ST_DECIDE;
        end else if (count == COUNT_MAX) begin
          state_next = ST_ARM;
        end
      end
      ST_DECIDE:  state_next = edge_det ? ST_DECIDE : ST_MEASURE;
      default:    state_next = ST_IDLE;
    endcase
    if (!enable) begin
      state_next = ST_IDLE;
    end
  end

  // Period counter, period latch and no-signal flag. The counter restarts
  // at 1 on the edge that closes a period, so the next period is counted
  // from that very cycle and no edge is lost.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      count     <= '0;
      period    <= '0;
      no_signal <= 1'b0;
    end else if (!enable) begin
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          count <= '0;
        end
        ST_ARM: begin
          if (edge_det) begin
            count     <= period_t'(1);
            no_signal <= 1'b0;
          end else if (timeout) begin
            no_signal <= 1'b1;
          end else begin
            count <= count + period_t'(1);
          end
        end
        ST_MEASURE, ST_DECIDE: begin
          if (edge_det) begin
            period    <= count;
            count     <= period_t'(1);
            no_signal <= 1'b0;
          end else if (timeout) begin
            no_signal <= 1'b1;
          end else if (count != COUNT_MAX) begin
            count <= count + period_t'(1);
          end
        end
        default: begin
          count <= '0;
        end
      endcase
    end
  end

  // Note decision and lock tracking. A new note is reported only when the
  // match count reaches LOCK_COUNT and it is not already the locked note;
  // a non-matching period drops lock but keeps the last reported note.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      note       <= '0;
      note_valid <= 1'b0;
      locked     <= 1'b0;
      match_cnt  <= '0;
      match_last <= '0;
    end else begin
      note_valid <= 1'b0;
      if (!enable) begin
        match_cnt <= '0;
      end else if (timeout) begin
        locked    <= 1'b0;
        match_cnt <= '0;
      end else if (state == ST_DECIDE) begin
        if (any_match) begin
          match_last <= match_idx;
          match_cnt  <= match_cnt_next;
          if (match_cnt_next >= LOCK_CNT) begin
            locked <= 1'b1;
            if (!locked || (match_idx != note)) begin
              note       <= match_idx;
              note_valid <= 1'b1;
            end
          end else begin
            locked <= 1'b0;
          end
        end else begin
          match_cnt <= '0;
          locked    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_note_decoder.sv
// tb_note_decoder
// Self-checking bench for note_decoder. A continuous square wave is built
// period by period; every note_valid pulse is matched against a queue of
// expected notes pushed by the scenario tasks.
module tb_note_decoder;
  import note_pkg::*;

  localparam int SETTLE   = 8;
  localparam int NO_SIG_T = 262144;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                wave_in = 1'b0;
  logic                enable = 1'b0;
  logic [NOTE_W-1:0]   note;
  logic                note_valid;
  logic                locked;
  logic                no_signal;
  logic [PERIOD_W-1:0] period;

  int total = 0;
  int bad   = 0;
  logic [NOTE_W-1:0] exp_q [$];

  note_decoder #(.TOL_SHIFT(6), .LOCK_COUNT(2)) dut (
    .CLOCK_50   (clk),
    .reset_n    (reset_n),
    .wave_in    (wave_in),
    .enable     (enable),
    .note       (note),
    .note_valid (note_valid),
    .locked     (locked),
    .no_signal  (no_signal),
    .period     (period)
  );

  // 50 MHz clock.
  always #10 clk = ~clk;

  // Hard stop in case something stalls.
  initial begin
    #80000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard consumer: every note_valid pulse must match the next
  // expected note.
  always @(negedge clk) begin
    if (note_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_pulse: got note_valid with note=%0d, none expected", note);
      end else begin
        logic [NOTE_W-1:0] e;
        e = exp_q.pop_front();
        if (note !== e) begin
          bad++;
          $display("[TB] FAIL pulse_note: got %0d want %0d", note, e);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise the wave and let the decoder react; rises are exactly p apart
  // when start_period and end_period are paired.
  task automatic start_period(input int p);
    wave_in = 1'b1;
    wait_cycles(SETTLE);
  endtask

  task automatic end_period(input int p);
    wait_cycles(p / 2 - SETTLE);
    wave_in = 1'b0;
    wait_cycles(p - p / 2);
  endtask

  task automatic check_all_zero(input string tag);
    total++; if (note !== 3'd0) begin bad++; $display("[TB] FAIL %s_note: got %0d want 0", tag, note); end
    total++; if (note_valid !== 1'b0) begin bad++; $display("[TB] FAIL %s_valid: got %0b want 0", tag, note_valid); end
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL %s_locked: got %0b want 0", tag, locked); end
    total++; if (no_signal !== 1'b0) begin bad++; $display("[TB] FAIL %s_nosig: got %0b want 0", tag, no_signal); end
    total++; if (period !== 18'd0) begin bad++; $display("[TB] FAIL %s_period: got %0d want 0", tag, period); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; wave_in = 1'b0;
    wait_cycles(4);
    check_all_zero("reset");
    reset_n = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_lock();
    enable = 1'b1;
    wait_cycles(4);
    exp_q.push_back(3'd5);
    for (int i = 0; i < 5; i++) begin
      start_period(113636);
      if (i == 4) begin
        total++; if (note !== 3'd5) begin bad++; $display("[TB] FAIL lock_note: got %0d want 5", note); end
        total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL lock_locked: got %0b want 1", locked); end
        total++; if (period !== 18'd113636) begin bad++; $display("[TB] FAIL lock_period: got %0d want 113636", period); end
        total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL lock_pulse: got %0d pending want 0", exp_q.size()); end
      end
      end_period(113636);
    end
  endtask

  task automatic test_note_change();
    exp_q.push_back(3'd7);
    start_period(95556);
    total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL chg_keep_lock: got %0b want 1", locked); end
    end_period(95556);
    start_period(95556);
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL chg_unlock: got %0b want 0", locked); end
    total++; if (note !== 3'd5) begin bad++; $display("[TB] FAIL chg_hold_note: got %0d want 5", note); end
    total++; if (period !== 18'd95556) begin bad++; $display("[TB] FAIL chg_period: got %0d want 95556", period); end
    end_period(95556);
    start_period(95556);
    total++; if (note !== 3'd7) begin bad++; $display("[TB] FAIL chg_note: got %0d want 7", note); end
    total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL chg_relock: got %0b want 1", locked); end
    total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL chg_pulse: got %0d pending want 0", exp_q.size()); end
    end_period(95556);
  endtask

  task automatic test_off_tolerance();
    start_period(110000);
    end_period(110000);
    start_period(110000);
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL off_locked: got %0b want 0", locked); end
    total++; if (note !== 3'd7) begin bad++; $display("[TB] FAIL off_note: got %0d want 7", note); end
    total++; if (period !== 18'd110000) begin bad++; $display("[TB] FAIL off_period: got %0d want 110000", period); end
    end_period(110000);
  endtask

  task automatic test_no_signal();
    exp_q.push_back(3'd7);
    start_period(95556); end_period(95556);
    start_period(95556); end_period(95556);
    start_period(95556);
    total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL nosig_prelock: got %0b want 1", locked); end
    wave_in = 1'b0;
    wait_cycles(NO_SIG_T - 16 - SETTLE);
    total++; if (no_signal !== 1'b0) begin bad++; $display("[TB] FAIL nosig_early: got %0b want 0", no_signal); end
    wait_cycles(32);
    total++; if (no_signal !== 1'b1) begin bad++; $display("[TB] FAIL nosig_set: got %0b want 1", no_signal); end
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL nosig_locked: got %0b want 0", locked); end
    wait_cycles(300000 - NO_SIG_T - 16);
    start_period(191110);
    total++; if (no_signal !== 1'b0) begin bad++; $display("[TB] FAIL nosig_clear: got %0b want 0", no_signal); end
  endtask

  task automatic test_reset_mid();
    wave_in = 1'b0;
    wait_cycles(1000);
    reset_n = 1'b0;
    wait_cycles(1);
    reset_n = 1'b1;
    check_all_zero("midrst");
    wait_cycles(100);
    exp_q.push_back(3'd0);
    start_period(191110); end_period(191110);
    start_period(191110); end_period(191110);
    start_period(191110);
    total++; if (note !== 3'd0) begin bad++; $display("[TB] FAIL midrst_note: got %0d want 0", note); end
    total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL midrst_locked: got %0b want 1", locked); end
    total++; if (period !== 18'd191110) begin bad++; $display("[TB] FAIL midrst_period: got %0d want 191110", period); end
    total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL midrst_pulse: got %0d pending want 0", exp_q.size()); end
    end_period(191110);
  endtask

  task automatic test_boundary();
    exp_q.push_back(3'd6);
    start_period(102820); end_period(102820);
    start_period(102820); end_period(102820);
    start_period(102820);
    total++; if (note !== 3'd6) begin bad++; $display("[TB] FAIL bnd_in_note: got %0d want 6", note); end
    total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL bnd_in_locked: got %0b want 1", locked); end
    total++; if (period !== 18'd102820) begin bad++; $display("[TB] FAIL bnd_in_period: got %0d want 102820", period); end
    end_period(102820);
    start_period(102821); end_period(102821);
    start_period(102821);
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL bnd_out_locked: got %0b want 0", locked); end
    total++; if (period !== 18'd102821) begin bad++; $display("[TB] FAIL bnd_out_period: got %0d want 102821", period); end
    total++; if (note !== 3'd6) begin bad++; $display("[TB] FAIL bnd_out_note: got %0d want 6", note); end
    end_period(102821);
  endtask

  task automatic test_enable_hold();
    wait_cycles(500);
    enable = 1'b0;
    wait_cycles(5);
    total++; if (period !== 18'd102821) begin bad++; $display("[TB] FAIL hold_period: got %0d want 102821", period); end
    total++; if (note !== 3'd6) begin bad++; $display("[TB] FAIL hold_note: got %0d want 6", note); end
    total++; if (note_valid !== 1'b0) begin bad++; $display("[TB] FAIL hold_valid: got %0b want 0", note_valid); end
  endtask

  initial begin
    $display("[TB] note_decoder bench start");
    test_reset();
    test_lock();
    test_note_change();
    test_off_tolerance();
    test_no_signal();
    test_reset_mid();
    test_boundary();
    test_enable_hold();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL final_queue: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
